// File: rtl/cop0_write_sequencer_if.sv
// COP0 write sequencer bus: request/ack pairs from the pipeline, forwarded Status/Cause,
// and the single COP0 register-file write port.
// master = pipeline/hazard side, slave = the sequencer itself.
interface cop0_write_sequencer_if;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_ack;
  logic        exc_done;
  logic        eret_req;
  logic        eret_ack;
  logic        mtc0_req;
  logic [4:0]  mtc0_rd;
  logic [2:0]  mtc0_sel;
  logic [31:0] mtc0_data;
  logic        mtc0_ack;
  logic [31:0] status;
  logic [31:0] cause;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic        busy;

  modport master (
    output exc_req, exc_code, exc_pc, exc_bd, eret_req,
           mtc0_req, mtc0_rd, mtc0_sel, mtc0_data, status, cause,
    input  exc_ack, exc_done, eret_ack, mtc0_ack,
           wr_en, wr_rd, wr_sel, wr_data, busy
  );

  modport slave (
    input  exc_req, exc_code, exc_pc, exc_bd, eret_req,
           mtc0_req, mtc0_rd, mtc0_sel, mtc0_data, status, cause,
    output exc_ack, exc_done, eret_ack, mtc0_ack,
           wr_en, wr_rd, wr_sel, wr_data, busy
  );
endinterface

// File: rtl/cop0_write_sequencer.sv
// Arbitrates exception entry / ERET / MTC0 onto the single COP0 write port.
// Latency: MTC0/ERET write 1 cycle after ack; exception writes at +1..+3 (+1..+2 if EXL already set).
// Backpressure: requests are only arbitrated in IDLE; while busy they are ignored and must be held.
module cop0_write_sequencer #(
  parameter logic [4:0] EPC_RD    = 5'd14,
  parameter logic [4:0] CAUSE_RD  = 5'd13,
  parameter logic [4:0] STATUS_RD = 5'd12
) (
  input logic                 clk,
  input logic                 reset,
  cop0_write_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MTC0       = 3'd1,
    EXC_EPC    = 3'd2,
    EXC_CAUSE  = 3'd3,
    EXC_STATUS = 3'd4,
    ERET       = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  code_q;
  logic        bd_q;
  logic [31:0] pc_q;
  logic        exl_old_q;
  logic [4:0]  rd_q;
  logic [2:0]  sel_q;
  logic [31:0] data_q;

  logic        in_idle;
  logic        accept_exc;
  logic        accept_eret;
  logic        accept_mtc0;
  logic        wr_en_c;
  logic [4:0]  wr_rd_c;
  logic [2:0]  wr_sel_c;
  logic [31:0] wr_data_c;
  logic        exc_done_c;

  // Acks are decoded from the IDLE state and the live requests, so the winner is
  // acknowledged in the same cycle it is arbitrated; reset forces them low.
  assign in_idle     = (state_q == IDLE) && !reset;
  assign accept_exc  = in_idle && bus.exc_req;
  assign accept_eret = in_idle && !bus.exc_req && bus.eret_req;
  assign accept_mtc0 = in_idle && !bus.exc_req && !bus.eret_req && bus.mtc0_req;

  // State register; reset abandons any in-flight sequence immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture the accepted request's operands so the sequence is immune to the
  // pipeline changing them after the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q    <= '0;
      bd_q      <= 1'b0;
      pc_q      <= '0;
      exl_old_q <= 1'b0;
      rd_q      <= '0;
      sel_q     <= '0;
      data_q    <= '0;
    end else begin
      if (accept_exc) begin
        code_q    <= bus.exc_code;
        bd_q      <= bus.exc_bd;
        pc_q      <= bus.exc_pc;
        exl_old_q <= bus.status[1];
      end
      if (accept_mtc0) begin
        rd_q   <= bus.mtc0_rd;
        sel_q  <= bus.mtc0_sel;
        data_q <= bus.mtc0_data;
      end
    end
  end

  // Next-state and write-port decode. Cause/Status writes merge into the live
  // forwarded values so concurrent hardware updates to other bits are kept.
  always_comb begin
    state_d    = state_q;
    wr_en_c    = 1'b0;
    wr_rd_c    = 5'd0;
    wr_sel_c   = 3'd0;
    wr_data_c  = 32'd0;
    exc_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_exc)       state_d = bus.status[1] ? EXC_CAUSE : EXC_EPC;
        else if (accept_eret) state_d = ERET;
        else if (accept_mtc0) state_d = MTC0;
      end
      MTC0: begin
        wr_en_c   = 1'b1;
        wr_rd_c   = rd_q;
        wr_sel_c  = sel_q;
        wr_data_c = data_q;
        state_d   = IDLE;
      end
      EXC_EPC: begin
        wr_en_c   = 1'b1;
        wr_rd_c   = EPC_RD;
        wr_data_c = bd_q ? (pc_q - 32'd4) : pc_q;
        state_d   = EXC_CAUSE;
      end
      EXC_CAUSE: begin
        wr_en_c        = 1'b1;
        wr_rd_c        = CAUSE_RD;
        wr_data_c      = bus.cause;
        wr_data_c[6:2] = code_q;
        // BD only describes the new EPC; with EXL already set EPC is untouched.
        if (!exl_old_q) wr_data_c[31] = bd_q;
        state_d        = EXC_STATUS;
      end
      EXC_STATUS: begin
        wr_en_c    = 1'b1;
        wr_rd_c    = STATUS_RD;
        wr_data_c  = bus.status | 32'h0000_0002;
        exc_done_c = 1'b1;
        state_d    = IDLE;
      end
      ERET: begin
        wr_en_c   = 1'b1;
        wr_rd_c   = STATUS_RD;
        wr_data_c = bus.status;
        // ERL takes precedence over EXL when leaving an exception level.
        if (bus.status[2]) wr_data_c[2] = 1'b0;
        else               wr_data_c[1] = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.exc_ack  = accept_exc;
  assign bus.eret_ack = accept_eret;
  assign bus.mtc0_ack = accept_mtc0;
  assign bus.exc_done = exc_done_c;
  assign bus.wr_en    = wr_en_c;
  assign bus.wr_rd    = wr_rd_c;
  assign bus.wr_sel   = wr_sel_c;
  assign bus.wr_data  = wr_data_c;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: doc/cop0_write_sequencer.md
Name: cop0_write_sequencer

Overview:
- Owns the single COP0 register-file write port and shares it between three requesters: exception entry, ERET, and pipeline MTC0.
- Exception entry needs three writes (EPC, Cause, Status), so the block issues them on consecutive cycles.
- Sits between the execute stage and the COP0 register file.
- Raises `busy` so the hazard unit stalls fetch through execute while a sequence is in flight.

Parameters:
- EPC_RD, 14, rd index of EPC (sel 0)
- CAUSE_RD, 13, rd index of Cause (sel 0)
- STATUS_RD, 12, rd index of Status (sel 0)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- exc_req  in  1  exception request (level, sampled in IDLE)
- exc_code  in  5  ExcCode for Cause[6:2]
- exc_pc  in  32  PC of the faulting instruction
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_ack  out  1  one-cycle pulse, exception accepted
- exc_done  out  1  one-cycle pulse, Status write issued (redirect to vector allowed)
- eret_req  in  1  ERET request
- eret_ack  out  1  one-cycle pulse, ERET accepted
- mtc0_req  in  1  MTC0 request
- mtc0_rd  in  5  MTC0 destination rd
- mtc0_sel  in  3  MTC0 destination sel
- mtc0_data  in  32  already write-filtered MTC0 data
- mtc0_ack  out  1  one-cycle pulse, MTC0 accepted
- status  in  32  current Status value (forwarded)
- cause  in  32  current Cause value
- wr_en  out  1  COP0 write enable
- wr_rd  out  5  COP0 write rd
- wr_sel  out  3  COP0 write sel
- wr_data  out  32  COP0 write data
- busy  out  1  sequence in flight

Behaviour:
- States: IDLE, MTC0, EXC_EPC, EXC_CAUSE, EXC_STATUS, ERET.
- All outputs are registered or decoded from the state register. Reset puts the block in IDLE with every output 0.
- Arbitration happens only in IDLE. Priority is exc_req > eret_req > mtc0_req. The chosen request gets its ack pulse in the acceptance cycle. Losers get no ack and must re-request; a simultaneous MTC0 or ERET is normally flushed by the exception.
- Exception acceptance:
  - Latch exc_code, exc_bd, exc_pc, plus exl_old = status[1] and erl_old = status[2].
  - If exl_old=0, next state is EXC_EPC; otherwise EXC_CAUSE. No EPC write and no BD update when EXL is already set.
- EXC_EPC: wr_en=1, wr_rd=EPC_RD, wr_sel=0. wr_data = exc_pc-4 if exc_bd, else exc_pc (mod 2^32, so 0 wraps to FFFFFFFC). Next state EXC_CAUSE.
- EXC_CAUSE:
  - wr_data = cause with [6:2] replaced by exc_code.
  - Bit 31 is set to exc_bd if exl_old=0, and left unchanged otherwise.
  - All other bits come from the live `cause` input sampled this cycle.
  - Next state EXC_STATUS.
- EXC_STATUS: wr_data = live status with bit1 (EXL) set. exc_done pulses in this cycle. Next state IDLE.
- ERET acceptance: next state ERET. In ERET, wr_data = status with bit2 cleared if status[2]=1, else bit1 cleared. Next state IDLE.
- MTC0 acceptance: latch rd, sel and data. In MTC0, write the latched values. Next state IDLE.
- Latency:
  - MTC0 and ERET write 1 cycle after ack.
  - Exception writes land on cycles +1/+2/+3 after ack when EXL=0, or +1/+2 when EXL=1.
- busy = (state != IDLE). Requests arriving while busy are ignored (no ack).
- wr_en is high exactly in the non-IDLE states and never for more than 3 consecutive cycles per request.
- Back-to-back: a request held high through a sequence is re-arbitrated in the IDLE cycle that follows. There is at least one idle cycle between sequences.
- exc_req arriving during an in-flight MTC0 or ERET is accepted at the next IDLE.
- Reset asserted mid-sequence returns immediately to IDLE with all outputs 0. Remaining writes are abandoned.

Test Plan:
- Reset, then exc_req with code 0x0C, pc 0xBFC00100, bd=0, status=0x00000000, cause=0 → exc_ack at T0; writes at T1 EPC=0xBFC00100, T2 Cause=0x00000030, T3 Status=0x00000002; exc_done at T3; busy T1-T3.
- exc_req with bd=1, pc 0x80000004, status EXL=1, cause=0x00000400, code 0x04 → only two writes: Cause=0x00000410 (bit31 unchanged), then Status with EXL set; no EPC write.
- eret_req with status=0x00000006 → Status write 0x00000002 (ERL cleared). Repeat with status=0x00000002 → write 0x00000000.
- exc_req, eret_req and mtc0_req in the same cycle → only exc_ack; 3-write exception sequence; mtc0_ack and eret_ack stay 0.
- mtc0_req rd=12 sel=0 data=0x0000FF01, held through an in-flight exception → acked at first IDLE after EXC_STATUS; write one cycle later.
- Reset asserted in EXC_CAUSE → wr_en, busy and all pulses drop to 0 immediately; no Status write follows after reset release.
